// File: rtl/bp_me_irq_forwarder_pkg.sv
// Shared types and constants for the CLINT external-interrupt forwarder.
package bp_me_irq_forwarder_pkg;

  localparam int unsigned paddr_width_gp        = 40;
  localparam int unsigned lce_id_width_gp       = 4;
  localparam int unsigned did_width_gp          = 3;
  localparam int unsigned bedrock_fill_width_gp = 64;

  // PLIC register pair inside the CLINT slice; entry 0 is M, entry 1 is S.
  localparam logic [paddr_width_gp-1:0] plic_reg_base_addr_gp = 40'h00_0030_b000;
  localparam int unsigned               plic_stride_lp        = 4;

  // Forwarder FSM state encoding.
  localparam logic [1:0] e_idle = 2'd0;
  localparam logic [1:0] e_send = 2'd1;
  localparam logic [1:0] e_wait = 2'd2;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'b0000,
    e_bedrock_mem_wr    = 4'b0001,
    e_bedrock_mem_uc_rd = 4'b0010,
    e_bedrock_mem_uc_wr = 4'b0011,
    e_bedrock_mem_pre   = 4'b0100,
    e_bedrock_mem_amo   = 4'b0101
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'b000,
    e_bedrock_msg_size_2   = 3'b001,
    e_bedrock_msg_size_4   = 3'b010,
    e_bedrock_msg_size_8   = 3'b011,
    e_bedrock_msg_size_16  = 3'b100,
    e_bedrock_msg_size_32  = 3'b101,
    e_bedrock_msg_size_64  = 3'b110,
    e_bedrock_msg_size_128 = 3'b111
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [did_width_gp-1:0]    did;
    logic [lce_id_width_gp-1:0] lce_id;
  } bp_bedrock_mem_payload_s;

  typedef struct packed {
    bp_bedrock_mem_payload_s    payload;
    bp_bedrock_msg_size_e       size;
    logic [paddr_width_gp-1:0]  addr;
    logic [3:0]                 subop;
    bp_bedrock_mem_type_e       msg_type;
  } bp_bedrock_mem_header_s;

  localparam int unsigned mem_fwd_header_width_lp = $bits(bp_bedrock_mem_header_s);
  localparam int unsigned mem_rev_header_width_lp = $bits(bp_bedrock_mem_header_s);

endpackage

// File: rtl/bp_me_irq_forwarder_pending.sv
// Synchronizes raw IRQ lines, tracks sticky edge pending and reduces to M/S levels.
module bp_me_irq_pending
  import bp_me_irq_forwarder_pkg::*;
 #(parameter int unsigned            num_src_p   = 8
  ,parameter logic [num_src_p-1:0]   edge_mask_p = '0
  )
  (input  logic                 clk_i
  ,input  logic                 reset_n_i
  ,input  logic [num_src_p-1:0] irq_src_i
  ,input  logic [num_src_p-1:0] m_en_i
  ,input  logic [num_src_p-1:0] s_en_i
  ,input  logic [num_src_p-1:0] clear_i
  ,output logic [num_src_p-1:0] pending_o
  ,output logic                 m_lvl_c
  ,output logic                 s_lvl_c
  );

  logic [num_src_p-1:0] sync_meta_r, sync_r, sync_d_r, edge_pend_r;

  // Two-flop synchronizer, edge-detect delay and sticky edge pending (set beats clear).
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_meta_r <= '0;
      sync_r      <= '0;
      sync_d_r    <= '0;
      edge_pend_r <= '0;
    end else begin
      sync_meta_r <= irq_src_i;
      sync_r      <= sync_meta_r;
      sync_d_r    <= sync_r;
      edge_pend_r <= (sync_r & ~sync_d_r) | (edge_pend_r & ~clear_i);
    end
  end

  // Per-source select between level and sticky edge pending, then mode reduction.
  always_comb begin
    pending_o = (sync_r & ~edge_mask_p) | (edge_pend_r & edge_mask_p);
    m_lvl_c   = |(pending_o & m_en_i);
    s_lvl_c   = |(pending_o & s_en_i);
  end

endmodule

// File: rtl/bp_me_irq_forwarder.sv
// Forwards aggregated M/S external-interrupt levels to the CLINT as uncached writes.
module bp_me_irq_forwarder
  import bp_me_irq_forwarder_pkg::*;
 #(parameter int unsigned                num_src_p        = 8
  ,parameter logic [num_src_p-1:0]       edge_mask_p      = '0
  ,parameter logic [paddr_width_gp-1:0]  plic_base_addr_p = plic_reg_base_addr_gp
  ,parameter logic [lce_id_width_gp-1:0] src_lce_id_p     = '0
  ,parameter logic [did_width_gp-1:0]    src_did_p        = '0
  )
  (input  logic                                clk_i
  ,input  logic                                reset_n_i
  ,input  logic [num_src_p-1:0]                irq_src_i
  ,input  logic [num_src_p-1:0]                m_en_i
  ,input  logic [num_src_p-1:0]                s_en_i
  ,input  logic [num_src_p-1:0]                clear_i
  ,output logic [num_src_p-1:0]                pending_o
  ,output logic [mem_fwd_header_width_lp-1:0]  mem_fwd_header_o
  ,output logic [bedrock_fill_width_gp-1:0]    mem_fwd_data_o
  ,output logic                                mem_fwd_v_o
  ,input  logic                                mem_fwd_ready_and_i
  ,input  logic [mem_rev_header_width_lp-1:0]  mem_rev_header_i
  ,input  logic [bedrock_fill_width_gp-1:0]    mem_rev_data_i
  ,input  logic                                mem_rev_v_i
  ,output logic                                mem_rev_ready_and_o
  ,output logic                                busy_o
  );

  localparam logic [paddr_width_gp-1:0] plic_s_addr_lp =
    plic_base_addr_p + paddr_width_gp'(plic_stride_lp);

  logic                   m_lvl_c, s_lvl_c;
  logic [1:0]             state_r, state_n;
  logic                   tgt_r, tgt_n, val_r, val_n;
  logic [1:0]             sent_r, sent_n;
  logic                   fwd_v_r, rev_ready_r, busy_r;
  bp_bedrock_mem_header_s fwd_hdr;
  logic                   unused_rev;

  // The response carries nothing we need beyond its valid.
  assign unused_rev = ^{mem_rev_header_i, mem_rev_data_i};

  bp_me_irq_pending
   #(.num_src_p(num_src_p), .edge_mask_p(edge_mask_p))
   pending
    (.clk_i     (clk_i)
    ,.reset_n_i (reset_n_i)
    ,.irq_src_i (irq_src_i)
    ,.m_en_i    (m_en_i)
    ,.s_en_i    (s_en_i)
    ,.clear_i   (clear_i)
    ,.pending_o (pending_o)
    ,.m_lvl_c   (m_lvl_c)
    ,.s_lvl_c   (s_lvl_c)
    );

  // Next-state: pick a mismatching level (M first), send it, then commit on response.
  always_comb begin
    state_n = state_r;
    tgt_n   = tgt_r;
    val_n   = val_r;
    sent_n  = sent_r;
    case (state_r)
      e_idle: begin
        if (m_lvl_c != sent_r[0]) begin
          tgt_n   = 1'b0;
          val_n   = m_lvl_c;
          state_n = e_send;
        end else if (s_lvl_c != sent_r[1]) begin
          tgt_n   = 1'b1;
          val_n   = s_lvl_c;
          state_n = e_send;
        end
      end
      e_send: begin
        if (mem_fwd_ready_and_i) state_n = e_wait;
      end
      e_wait: begin
        if (mem_rev_v_i) begin
          sent_n[tgt_r] = val_r;
          state_n       = e_idle;
        end
      end
      default: state_n = e_idle;
    endcase
  end

  // State, latched request and registered handshake/status outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= e_idle;
      tgt_r       <= 1'b0;
      val_r       <= 1'b0;
      sent_r      <= 2'b00;
      fwd_v_r     <= 1'b0;
      rev_ready_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      tgt_r       <= tgt_n;
      val_r       <= val_n;
      sent_r      <= sent_n;
      fwd_v_r     <= (state_n == e_send);
      rev_ready_r <= (state_n == e_wait);
      busy_r      <= (state_n != e_idle);
    end
  end

  // Request header built from the latched target; stable for the whole SEND phase.
  always_comb begin
    fwd_hdr                = '0;
    fwd_hdr.msg_type       = e_bedrock_mem_uc_wr;
    fwd_hdr.addr           = tgt_r ? plic_s_addr_lp : plic_base_addr_p;
    fwd_hdr.size           = e_bedrock_msg_size_8;
    fwd_hdr.payload.lce_id = src_lce_id_p;
    fwd_hdr.payload.did    = src_did_p;
  end

  assign mem_fwd_header_o    = fwd_hdr;
  assign mem_fwd_data_o      = bedrock_fill_width_gp'(val_r);
  assign mem_fwd_v_o         = fwd_v_r;
  assign mem_rev_ready_and_o = rev_ready_r;
  assign busy_o              = busy_r;

endmodule

// File: tb/tb_bp_me_irq_forwarder.sv
// Directed plus randomized bench with a cycle-level reference model of the forwarder.
module tb_bp_me_irq_forwarder;
  import bp_me_irq_forwarder_pkg::*;

  localparam int unsigned N    = 8;
  localparam logic [N-1:0] EM  = 8'h88;
  localparam logic [39:0] BASE = 40'h00_0030_b000;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic         reset_n_i;
  logic [N-1:0] irq_src_i, m_en_i, s_en_i, clear_i, pending_o;
  logic [mem_fwd_header_width_lp-1:0] mem_fwd_header_o;
  logic [63:0]  mem_fwd_data_o;
  logic         mem_fwd_v_o, mem_fwd_ready_and_i;
  logic [mem_rev_header_width_lp-1:0] mem_rev_header_i;
  logic [63:0]  mem_rev_data_i;
  logic         mem_rev_v_i, mem_rev_ready_and_o, busy_o;

  bp_me_irq_forwarder #(.num_src_p(N), .edge_mask_p(EM)) dut
    (.clk_i(clk_i), .reset_n_i(reset_n_i), .irq_src_i(irq_src_i), .m_en_i(m_en_i),
     .s_en_i(s_en_i), .clear_i(clear_i), .pending_o(pending_o),
     .mem_fwd_header_o(mem_fwd_header_o), .mem_fwd_data_o(mem_fwd_data_o),
     .mem_fwd_v_o(mem_fwd_v_o), .mem_fwd_ready_and_i(mem_fwd_ready_and_i),
     .mem_rev_header_i(mem_rev_header_i), .mem_rev_data_i(mem_rev_data_i),
     .mem_rev_v_i(mem_rev_v_i), .mem_rev_ready_and_o(mem_rev_ready_and_o),
     .busy_o(busy_o));

  bp_bedrock_mem_header_s hdr;
  assign hdr = bp_bedrock_mem_header_s'(mem_fwd_header_o);

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: irq history (h1 newest), sticky edge bits, committed levels, phase.
  logic [N-1:0] h1, h2, h3, pe;
  logic [1:0]   sent;
  int           ph;       // 0 quiet, 1 request offered, 2 awaiting response
  int           m_tgt;
  logic         m_val;

  logic [39:0] log_addr[$];
  logic [63:0] log_data[$];

  // Accepted requests, as observed on the link.
  always @(negedge clk_i)
    if (reset_n_i && mem_fwd_v_o && mem_fwd_ready_and_i) begin
      log_addr.push_back(hdr.addr);
      log_data.push_back(mem_fwd_data_o);
    end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] model_pend();
    return (h2 & ~EM) | (pe & EM);
  endfunction

  task automatic model_reset();
    h1 = '0; h2 = '0; h3 = '0; pe = '0; sent = 2'b00; ph = 0; m_tgt = 0; m_val = 1'b0;
  endtask

  task automatic model_update();
    logic [N-1:0] p;
    logic m, s;
    if (!reset_n_i) begin
      model_reset();
    end else begin
      p = model_pend();
      m = |(p & m_en_i);
      s = |(p & s_en_i);
      if (ph == 0) begin
        if (m != sent[0])      begin ph = 1; m_tgt = 0; m_val = m; end
        else if (s != sent[1]) begin ph = 1; m_tgt = 1; m_val = s; end
      end else if (ph == 1) begin
        if (mem_fwd_ready_and_i) ph = 2;
      end else begin
        if (mem_rev_v_i) begin sent[m_tgt] = m_val; ph = 0; end
      end
      pe = (h2 & ~h3) | (pe & ~clear_i);
      h3 = h2; h2 = h1; h1 = irq_src_i;
    end
  endtask

  task automatic check();
    chk("pending", 64'(pending_o), 64'(model_pend()));
    chk("fwd_v", 64'(mem_fwd_v_o), 64'(ph == 1));
    chk("rev_ready", 64'(mem_rev_ready_and_o), 64'(ph == 2));
    chk("busy", 64'(busy_o), 64'(ph != 0));
    if (ph == 1) begin
      chk("msg_type", 64'(hdr.msg_type), 64'h3);
      chk("addr", 64'(hdr.addr), 64'(BASE + 40'(4 * m_tgt)));
      chk("size", 64'(hdr.size), 64'h3);
      chk("lce_id", 64'(hdr.payload.lce_id), 64'h0);
      chk("did", 64'(hdr.payload.did), 64'h0);
      chk("data", mem_fwd_data_o, 64'(m_val));
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    model_update();
    #1;
    check();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_v(input int budget);
    for (int i = 0; i < budget && !mem_fwd_v_o; i++) step();
    chk("wait_fwd_v", 64'(mem_fwd_v_o), 64'h1);
  endtask

  task automatic chk_log(input int idx, input logic [39:0] a, input logic d);
    if (idx < log_addr.size()) begin
      chk($sformatf("log%0d_addr", idx), 64'(log_addr[idx]), 64'(a));
      chk($sformatf("log%0d_data", idx), log_data[idx], 64'(d));
    end else begin
      chk($sformatf("log%0d_present", idx), 64'(log_addr.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    int vcnt;
    reset_n_i = 1'b0;
    irq_src_i = '0; m_en_i = '0; s_en_i = '0; clear_i = '0;
    mem_fwd_ready_and_i = 1'b1; mem_rev_v_i = 1'b1;
    mem_rev_header_i = '0; mem_rev_data_i = '0;
    model_reset();
    #2;
    chk("reset_fwd_v", 64'(mem_fwd_v_o), 64'h0);
    chk("reset_rev_ready", 64'(mem_rev_ready_and_o), 64'h0);
    chk("reset_busy", 64'(busy_o), 64'h0);
    chk("reset_pending", 64'(pending_o), 64'h0);
    run(2);
    reset_n_i = 1'b1;

    // Single level source into M.
    m_en_i = 8'h01; irq_src_i = 8'h01;
    wait_v(10);
    run(12);
    chk("s1_count", 64'(log_addr.size()), 64'd1);
    chk_log(0, BASE, 1'b1);
    irq_src_i = 8'h00;
    run(12);
    chk("s1_clear_count", 64'(log_addr.size()), 64'd2);
    chk_log(1, BASE, 1'b0);

    // Two sources: M then S in order.
    m_en_i = 8'h01; s_en_i = 8'h02; irq_src_i = 8'h03;
    run(16);
    chk("s2_count", 64'(log_addr.size()), 64'd4);
    chk_log(2, BASE, 1'b1);
    chk_log(3, BASE + 40'd4, 1'b1);
    irq_src_i = 8'h00;
    run(16);
    chk_log(4, BASE, 1'b0);
    chk_log(5, BASE + 40'd4, 1'b0);

    // Backpressure on the request channel.
    s_en_i = 8'h00; mem_fwd_ready_and_i = 1'b0; irq_src_i = 8'h01;
    vcnt = 0;
    for (int i = 0; i < 14; i++) begin step(); if (mem_fwd_v_o) vcnt++; end
    chk("s3_held_cycles", 64'(vcnt >= 10), 64'h1);
    chk("s3_no_accept", 64'(log_addr.size()), 64'd6);
    mem_fwd_ready_and_i = 1'b1;
    run(6);
    chk("s3_one_accept", 64'(log_addr.size()), 64'd7);
    chk_log(6, BASE, 1'b1);
    irq_src_i = 8'h00;
    run(12);
    chk_log(7, BASE, 1'b0);

    // Edge source 3: sticky pending, clear, clear colliding with a new edge.
    m_en_i = 8'h08; irq_src_i = 8'h08;
    step();
    irq_src_i = 8'h00;
    run(10);
    chk("s4_sticky", 64'(pending_o[3]), 64'h1);
    chk_log(8, BASE, 1'b1);
    clear_i = 8'h08; step(); clear_i = 8'h00;
    run(10);
    chk("s4_cleared", 64'(pending_o[3]), 64'h0);
    chk_log(9, BASE, 1'b0);
    irq_src_i = 8'h08; step();
    irq_src_i = 8'h00; step();
    clear_i = 8'h08; step(); clear_i = 8'h00;
    run(10);
    chk("s4_set_wins", 64'(pending_o[3]), 64'h1);
    chk_log(10, BASE, 1'b1);
    clear_i = 8'h08; step(); clear_i = 8'h00;
    run(10);
    chk_log(11, BASE, 1'b0);

    // Level drops while waiting for the response: commit then correct.
    m_en_i = 8'h01; irq_src_i = 8'h01; mem_rev_v_i = 1'b0;
    for (int i = 0; i < 15 && !mem_rev_ready_and_o; i++) step();
    chk("s5_in_wait", 64'(mem_rev_ready_and_o), 64'h1);
    irq_src_i = 8'h00;
    run(5);
    mem_rev_v_i = 1'b1;
    run(16);
    chk("s5_count", 64'(log_addr.size()), 64'd14);
    chk_log(12, BASE, 1'b1);
    chk_log(13, BASE, 1'b0);

    // Asynchronous reset while a request is offered.
    mem_fwd_ready_and_i = 1'b0; irq_src_i = 8'h01;
    wait_v(10);
    #2;
    reset_n_i = 1'b0;
    model_reset();
    #1;
    chk("s6_async_v", 64'(mem_fwd_v_o), 64'h0);
    chk("s6_async_busy", 64'(busy_o), 64'h0);
    check();
    irq_src_i = 8'h00;
    run(2);
    reset_n_i = 1'b1; mem_fwd_ready_and_i = 1'b1;
    run(20);
    chk("s6_no_writes", 64'(log_addr.size()), 64'd14);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) irq_src_i = N'($urandom);
      if ($urandom_range(0, 63) == 0) m_en_i = N'($urandom);
      if ($urandom_range(0, 63) == 0) s_en_i = N'($urandom);
      clear_i = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      mem_fwd_ready_and_i = ($urandom_range(0, 3) != 0);
      mem_rev_v_i = ($urandom_range(0, 2) != 0);
      mem_rev_header_i = mem_rev_header_width_lp'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
